// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and the input-stage FSM state type for the bus matrix.
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_DATA = 2'b10
    } in_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        mastlock;
    } addr_ctrl_t;

endpackage

// File: rtl/ahb_mtx_in_stage.sv
// AHB matrix slave-port input stage: holds an address phase until the decoder grants it.
// Optional user sideband (HAUSERS/auser_op) is enabled with AHB_MTX_IN_STAGE_USER_EN.
//
// state | meaning
// IDLE  | no transfer pending; live address phase passed straight to the decoder
// HOLD  | address phase captured but not yet granted; master stalled
// DATA  | granted transfer in its data phase; slave ready/response forwarded
module ahb_mtx_in_stage
    import ahb_mtx_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic        HMASTLOCKS,
    input  logic        HREADYS,
    output logic        HREADYOUTS,
    output logic [1:0]  HRESPS,
    output logic        sel_op,
    output logic [31:0] addr_op,
    output logic [1:0]  trans_op,
    output logic        write_op,
    output logic [2:0]  size_op,
    output logic [2:0]  burst_op,
    output logic [3:0]  prot_op,
    output logic        mastlock_op,
    output logic        held_tran_op,
    input  logic        active_op,
    input  logic        readyout_op,
    input  logic [1:0]  resp_op
`ifdef AHB_MTX_IN_STAGE_USER_EN
    ,
    input  logic [31:0] HAUSERS,
    output logic [31:0] auser_op
`endif
);

    in_state_t  state_q, state_d;
    addr_ctrl_t hold_q;
    logic       new_tran;

`ifdef AHB_MTX_IN_STAGE_USER_EN
    logic [31:0] auser_q;
`endif

    assign new_tran = HSELS & HREADYS & HTRANSS[1];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
`ifdef AHB_MTX_IN_STAGE_USER_EN
            auser_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            // The master is stalled while held, so a capture there would only clobber the pending transfer.
            if (new_tran && (state_q != ST_HOLD)) begin
                hold_q.addr     <= HADDRS;
                hold_q.trans    <= HTRANSS;
                hold_q.write    <= HWRITES;
                hold_q.size     <= HSIZES;
                hold_q.burst    <= HBURSTS;
                hold_q.prot     <= HPROTS;
                hold_q.mastlock <= HMASTLOCKS;
`ifdef AHB_MTX_IN_STAGE_USER_EN
                auser_q         <= HAUSERS;
`endif
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_op       = HSELS;
        addr_op      = HADDRS;
        trans_op     = HTRANSS;
        write_op     = HWRITES;
        size_op      = HSIZES;
        burst_op     = HBURSTS;
        prot_op      = HPROTS;
        mastlock_op  = HMASTLOCKS;
        held_tran_op = 1'b0;
        HREADYOUTS   = 1'b1;
        HRESPS       = HRESP_OKAY;
`ifdef AHB_MTX_IN_STAGE_USER_EN
        auser_op     = HAUSERS;
`endif
        case (state_q)
            ST_IDLE: begin
                if (new_tran)
                    state_d = active_op ? ST_DATA : ST_HOLD;
            end
            ST_HOLD: begin
                if (active_op)
                    state_d = ST_DATA;
                sel_op       = 1'b1;
                addr_op      = hold_q.addr;
                // Captured type is NONSEQ or SEQ; the stall breaks any burst, so present NONSEQ.
                trans_op     = hold_q.trans & HTRANS_NONSEQ;
                write_op     = hold_q.write;
                size_op      = hold_q.size;
                burst_op     = hold_q.burst;
                prot_op      = hold_q.prot;
                mastlock_op  = hold_q.mastlock;
                held_tran_op = 1'b1;
                HREADYOUTS   = 1'b0;
`ifdef AHB_MTX_IN_STAGE_USER_EN
                auser_op     = auser_q;
`endif
            end
            ST_DATA: begin
                HREADYOUTS = readyout_op;
                HRESPS     = resp_op;
                if (readyout_op) begin
                    if (new_tran)
                        state_d = active_op ? ST_DATA : ST_HOLD;
                    else
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Scoreboard bench for ahb_mtx_in_stage: directed scenarios followed by randomized traffic.
module tb_ahb_mtx_in_stage;
    import ahb_mtx_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic        mastlock_op;
    logic        held_tran_op;
    logic        active_op;
    logic        readyout_op;
    logic [1:0]  resp_op;

    always #5 HCLK = ~HCLK;

    ahb_mtx_in_stage dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_op(sel_op), .addr_op(addr_op),
        .trans_op(trans_op), .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
        .prot_op(prot_op), .mastlock_op(mastlock_op), .held_tran_op(held_tran_op),
        .active_op(active_op), .readyout_op(readyout_op), .resp_op(resp_op)
    );

    typedef struct packed {
        logic        rst_n;
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic        active;
        logic        rdy;
        logic [1:0]  resp;
    } stim_t;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic        held;
        logic        ready;
        logic [1:0]  resp;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Reference model: a transfer is either waiting for its grant or occupying the data phase.
    bit    m_waiting;
    bit    m_in_data;
    stim_t m_cap;
    stim_t prev;
    logic  prev_hready;

    function automatic stim_t mk(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                                 input logic active, input logic rdy, input logic [1:0] resp,
                                 input logic rst_n);
        stim_t s;
        s.rst_n  = rst_n;
        s.sel    = sel;
        s.addr   = addr;
        s.trans  = trans;
        s.write  = 1'($urandom);
        s.size   = 3'($urandom);
        s.burst  = 3'($urandom);
        s.prot   = 4'($urandom);
        s.lock   = 1'($urandom);
        s.active = active;
        s.rdy    = rdy;
        s.resp   = resp;
        return s;
    endfunction

    task automatic model_step();
        logic req;
        req = prev.sel & prev_hready & (prev.trans == 2'b10 || prev.trans == 2'b11);
        if (!prev.rst_n) begin
            m_waiting = 0;
            m_in_data = 0;
            m_cap     = '0;
        end else if (m_waiting) begin
            if (prev.active) begin
                m_waiting = 0;
                m_in_data = 1;
            end
        end else if (!(m_in_data && !prev.rdy)) begin
            if (req) begin
                m_cap     = prev;
                m_in_data = prev.active;
                m_waiting = !prev.active;
            end else begin
                m_in_data = 0;
            end
        end
    endtask

    task automatic apply(input stim_t s, input string tag);
        exp_t e;
        @(posedge HCLK);
        model_step();
        #1;
        e.held  = m_waiting;
        e.ready = m_waiting ? 1'b0 : (m_in_data ? s.rdy : 1'b1);
        e.resp  = (m_in_data && !m_waiting) ? s.resp : 2'b00;
        if (m_waiting) begin
            e.sel = 1'b1;  e.addr = m_cap.addr;   e.trans = 2'b10;        e.write = m_cap.write;
            e.size = m_cap.size; e.burst = m_cap.burst; e.prot = m_cap.prot; e.lock = m_cap.lock;
        end else begin
            e.sel = s.sel; e.addr = s.addr; e.trans = s.trans; e.write = s.write;
            e.size = s.size; e.burst = s.burst; e.prot = s.prot; e.lock = s.lock;
        end
        HRESETn = s.rst_n;  HSELS = s.sel;     HADDRS = s.addr;   HTRANSS = s.trans;
        HWRITES = s.write;  HSIZES = s.size;   HBURSTS = s.burst; HPROTS = s.prot;
        HMASTLOCKS = s.lock; active_op = s.active; readyout_op = s.rdy; resp_op = s.resp;
        HREADYS = e.ready;  // single master on this port: bus HREADY is our own HREADYOUT
        prev = s;
        prev_hready = e.ready;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        string t;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = '{sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
                      mastlock_op, held_tran_op, HREADYOUTS, HRESPS};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got %h expected %h", t, $time, a, e);
                end
            end
        end
    end

    initial begin : stimulus
        HRESETn = 0; HSELS = 0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 0; HSIZES = '0;
        HBURSTS = '0; HPROTS = '0; HMASTLOCKS = 0; HREADYS = 1; active_op = 0;
        readyout_op = 1; resp_op = 2'b00;
        prev = '0;
        prev_hready = 1'b1;
        m_waiting = 0; m_in_data = 0; m_cap = '0;

        apply(mk(1, 32'h1111_0000, 2'b10, 0, 1, 2'b00, 0), "reset0");
        apply(mk(1, 32'h1111_0004, 2'b10, 1, 1, 2'b01, 0), "reset1");

        apply(mk(1, 32'h3000_0000, 2'b01, 0, 1, 2'b00, 1), "busy_sel");
        apply(mk(1, 32'h3000_0004, 2'b00, 1, 1, 2'b00, 1), "idle_sel");
        apply(mk(0, 32'h3000_0008, 2'b00, 0, 1, 2'b00, 1), "idle_after");

        apply(mk(1, 32'h2000_0010, 2'b10, 1, 1, 2'b00, 1), "nonseq_granted");
        apply(mk(0, 32'h0,         2'b00, 0, 1, 2'b00, 1), "nonseq_data");

        apply(mk(1, 32'h4000_0004, 2'b11, 0, 1, 2'b00, 1), "seq_addr");
        apply(mk(1, 32'h5555_aaaa, 2'b10, 0, 1, 2'b00, 1), "hold1");
        apply(mk(1, 32'h6666_bbbb, 2'b11, 0, 1, 2'b00, 1), "hold2");
        apply(mk(0, 32'h7777_cccc, 2'b00, 1, 1, 2'b00, 1), "hold3");
        apply(mk(0, 32'h0,         2'b00, 0, 0, 2'b00, 1), "data_wait1");
        apply(mk(0, 32'h0,         2'b00, 0, 0, 2'b00, 1), "data_wait2");
        apply(mk(0, 32'h0,         2'b00, 0, 0, 2'b01, 1), "error1");
        apply(mk(0, 32'h0,         2'b00, 0, 1, 2'b01, 1), "error2");
        apply(mk(1, 32'h0,         2'b00, 0, 1, 2'b01, 1), "after_error");

        apply(mk(1, 32'h8000_0000, 2'b10, 1, 1, 2'b00, 1), "b2b_first");
        apply(mk(1, 32'h8000_0100, 2'b10, 0, 1, 2'b00, 1), "b2b_second");
        apply(mk(1, 32'h9000_0000, 2'b10, 0, 1, 2'b00, 0), "hold_reset");
        apply(mk(0, 32'h0,         2'b00, 1, 0, 2'b01, 1), "post_reset");

        for (int i = 0; i < 400; i++) begin
            apply(mk($urandom_range(0, 3) != 0, $urandom, 2'($urandom), 1'($urandom),
                     $urandom_range(0, 3) != 0, {1'b0, 1'($urandom)},
                     $urandom_range(0, 39) != 0), "random");
        end

        repeat (3) @(posedge HCLK);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
